// File: rtl/cmd_sched_pkg.sv
// Shared types and constants for the command scheduler.
//   state_e      : sequencer states
//   STAT_*       : bit positions inside the host status byte
//   *_DEF        : default oscillator rate and delay ceiling
//   delay_load() : converts a microsecond request into a down-counter preload
package cmd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DELAY = 2'd3
  } state_e;

  localparam int STAT_OVF  = 7;
  localparam int STAT_BUSY = 6;
  localparam int STAT_DLY  = 5;

  localparam int CLK_MHZ_DEF    = 24;
  localparam int MAX_UDELAY_DEF = 2730;

  localparam int CMD_W   = 4;
  localparam int ARG_W   = 8;
  localparam int ENTRY_W = CMD_W + ARG_W;
  localparam int DLY_W   = 16;

  // Saturate first, then scale: 24 * 2730 - 1 = 65519 still fits in 16 bits.
  // Only called with us != 0, so the subtraction never wraps.
  function automatic logic [DLY_W-1:0] delay_load(input logic [11:0] us,
                                                  input int          clk_mhz,
                                                  input int          max_us);
    logic [31:0] sat;
    sat = (32'(us) > 32'(max_us)) ? 32'(max_us) : 32'(us);
    return DLY_W'(32'(clk_mhz) * sat - 32'd1);
  endfunction

endpackage

// File: rtl/cmd_scheduler_fifo.sv
// cmd_fifo: synchronous FIFO holding queued {cmd,arg} entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and entry (ignored when full or flushing)
//   pop_i         : read request (ignored when empty); data_o is the head
//   flush_i       : empties the FIFO, wins over push and pop
//   count_o       : occupancy before this edge's push/pop
//   full_o/empty_o: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo
  import cmd_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [3:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == 4'(DEPTH));
  assign empty_o = (cnt_q == 4'd0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: queues host commands and issues them one at a time to the
// payload engine, then waits out the requested post-command delay.
//   osc_signal, reset_n        : sole clock, asynchronous active-low reset
//   push_valid/cmd/arg/ready   : host enqueue path
//   flush                      : empties the queue and clears overflow
//   cmd_start/cmd_nr/cmd_arg   : issue pulse and held command to the engine
//   cmd_done/cmd_delay_us      : completion pulse and post-command delay
//   status                     : {ovf, busy, delay, 0, count}, registered
//   idle                       : registered "IDLE and queue empty"
//
// state | meaning
// IDLE  | nothing running; issue when the queue holds an entry
// ISSUE | pop head into cmd_nr/cmd_arg, pulse cmd_start next cycle
// RUN   | engine busy, waiting for cmd_done
// DELAY | counting down CLK_MHZ*us cycles after a command
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CLK_MHZ    = CLK_MHZ_DEF,
  parameter int MAX_UDELAY = MAX_UDELAY_DEF
) (
  input  logic        osc_signal,
  input  logic        reset_n,
  input  logic        push_valid,
  input  logic [3:0]  push_cmd,
  input  logic [7:0]  push_arg,
  output logic        push_ready,
  input  logic        flush,
  output logic        cmd_start,
  output logic [3:0]  cmd_nr,
  output logic [7:0]  cmd_arg,
  input  logic        cmd_done,
  input  logic [11:0] cmd_delay_us,
  output logic [7:0]  status,
  output logic        idle
);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               ovf_q;
  logic               cmd_start_q;
  logic [CMD_W-1:0]   cmd_nr_q;
  logic [ARG_W-1:0]   cmd_arg_q;
  logic [7:0]         status_q, status_d;
  logic               idle_q;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [3:0]         fifo_cnt;

  assign fifo_pop = (state_q == ISSUE);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (osc_signal),
    .rst_ni  (reset_n),
    .push_i  (push_valid),
    .data_i  ({push_cmd, push_arg}),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      // A flush landing on the IDLE->ISSUE edge leaves nothing to pop;
      // fall back to IDLE without pulsing the engine.
      ISSUE: begin
        state_d = fifo_empty ? IDLE : RUN;
      end
      RUN: begin
        if (cmd_done) begin
          if (cmd_delay_us == 12'd0) begin
            state_d = IDLE;
          end else begin
            state_d = DELAY;
            dly_d   = delay_load(cmd_delay_us, CLK_MHZ, MAX_UDELAY);
          end
        end
      end
      DELAY: begin
        if (dly_q == '0) state_d = IDLE;
        else             dly_d   = dly_q - DLY_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d            = 8'h00;
    status_d[STAT_OVF]  = ovf_q;
    status_d[STAT_BUSY] = (state_q != IDLE);
    status_d[STAT_DLY]  = (state_q == DELAY);
    status_d[3:0]       = fifo_cnt;
  end

  always_ff @(posedge osc_signal or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      ovf_q       <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_nr_q    <= '0;
      cmd_arg_q   <= '0;
      status_q    <= 8'h00;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      // Full is judged on the pre-pop count; a flush drops the push silently.
      if (flush)                       ovf_q <= 1'b0;
      else if (push_valid && fifo_full) ovf_q <= 1'b1;
      cmd_start_q <= fifo_pop && !fifo_empty;
      if (fifo_pop && !fifo_empty) begin
        cmd_nr_q  <= fifo_head[ENTRY_W-1:ARG_W];
        cmd_arg_q <= fifo_head[ARG_W-1:0];
      end
      status_q    <= status_d;
      idle_q      <= (state_q == IDLE) && fifo_empty;
    end
  end

  assign push_ready = ~fifo_full;
  assign cmd_start  = cmd_start_q;
  assign cmd_nr     = cmd_nr_q;
  assign cmd_arg    = cmd_arg_q;
  assign status     = status_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// timestamp-based reference model.
module tb_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int CLK_MHZ = 24;
  localparam int MAX_UD  = 2730;

  logic        osc_signal   = 1'b0;
  logic        reset_n      = 1'b0;
  logic        push_valid   = 1'b0;
  logic [3:0]  push_cmd     = 4'd0;
  logic [7:0]  push_arg     = 8'd0;
  logic        flush        = 1'b0;
  logic        cmd_done     = 1'b0;
  logic [11:0] cmd_delay_us = 12'd0;
  logic        push_ready, cmd_start, idle;
  logic [3:0]  cmd_nr;
  logic [7:0]  cmd_arg, status;

  cmd_scheduler #(
    .DEPTH      (DEPTH),
    .CLK_MHZ    (CLK_MHZ),
    .MAX_UDELAY (MAX_UD)
  ) dut (
    .osc_signal   (osc_signal),
    .reset_n      (reset_n),
    .push_valid   (push_valid),
    .push_cmd     (push_cmd),
    .push_arg     (push_arg),
    .push_ready   (push_ready),
    .flush        (flush),
    .cmd_start    (cmd_start),
    .cmd_nr       (cmd_nr),
    .cmd_arg      (cmd_arg),
    .cmd_done     (cmd_done),
    .cmd_delay_us (cmd_delay_us),
    .status       (status),
    .idle         (idle)
  );

  initial forever #5 osc_signal = ~osc_signal;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: queue contents plus timestamps (edge numbers) of the
  // pending issue and of the moment the scheduler is free again.
  logic [11:0] mq[$];
  bit          m_in_cmd;
  int          m_start_edge;
  int          m_free_edge;
  bit          m_ovf;
  logic [3:0]  m_nr;
  logic [7:0]  m_arg;
  bit          e_start, e_idle, e_ready;
  logic [7:0]  e_status;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_init();
    mq.delete();
    m_in_cmd     = 1'b0;
    m_start_edge = -1;
    m_free_edge  = 0;
    m_ovf        = 1'b0;
    m_nr         = 4'd0;
    m_arg        = 8'd0;
  endfunction

  function automatic void model_step();
    int          e;
    int          pre_n;
    int          us_sat;
    bit          issue_prev, run_prev, idle_prev, dly_prev;
    logic [11:0] h;
    e          = cyc;
    pre_n      = mq.size();
    issue_prev = (m_start_edge == e);
    run_prev   = m_in_cmd;
    idle_prev  = !m_in_cmd && (m_start_edge < 0) && (e - 1 >= m_free_edge);
    dly_prev   = !m_in_cmd && (m_start_edge < 0) && (e - 1 < m_free_edge);

    e_status = {m_ovf, !idle_prev, dly_prev, 1'b0, 4'(pre_n)};
    e_idle   = idle_prev && (pre_n == 0);
    e_start  = 1'b0;

    if (idle_prev && pre_n > 0) m_start_edge = e + 1;
    if (issue_prev) begin
      m_start_edge = -1;
      if (pre_n > 0) begin
        h        = mq.pop_front();
        m_nr     = h[11:8];
        m_arg    = h[7:0];
        e_start  = 1'b1;
        m_in_cmd = 1'b1;
      end else begin
        m_free_edge = e;
      end
    end
    if (run_prev && cmd_done) begin
      us_sat      = (int'(cmd_delay_us) > MAX_UD) ? MAX_UD : int'(cmd_delay_us);
      m_in_cmd    = 1'b0;
      m_free_edge = e + CLK_MHZ * us_sat;
    end
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (push_valid) begin
      if (pre_n == DEPTH) m_ovf = 1'b1;
      else                mq.push_back({push_cmd, push_arg});
    end
    e_ready = (mq.size() < DEPTH);
  endfunction

  always @(posedge osc_signal) begin
    cyc++;
    if (reset_n) begin
      model_step();
      #1;
      if (reset_n) begin
        chk("m_cmd_start", 32'(cmd_start), 32'(e_start));
        chk("m_cmd_nr", 32'(cmd_nr), 32'(m_nr));
        chk("m_cmd_arg", 32'(cmd_arg), 32'(m_arg));
        chk("m_status", 32'(status), 32'(e_status));
        chk("m_idle", 32'(idle), 32'(e_idle));
        chk("m_push_ready", 32'(push_ready), 32'(e_ready));
      end
    end
  end

  task automatic push(input logic [3:0] c, input logic [7:0] a);
    push_valid = 1'b1;
    push_cmd   = c;
    push_arg   = a;
    @(negedge osc_signal);
    push_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [11:0] us);
    cmd_done     = 1'b1;
    cmd_delay_us = us;
    @(negedge osc_signal);
    cmd_done     = 1'b0;
    cmd_delay_us = 12'd0;
  endtask

  task automatic wait_start(input int limit);
    int n;
    n = 0;
    while (!cmd_start && n < limit) begin
      @(negedge osc_signal);
      n++;
    end
    chk("start_seen", 32'(cmd_start), 32'd1);
  endtask

  task automatic measure_delay(input logic [11:0] us, input int exp_cycles);
    int n, lim;
    n   = 0;
    lim = 0;
    pulse_done(us);
    while (lim < exp_cycles + 50) begin
      if (status[5]) n++;
      else if (n > 0) break;
      @(negedge osc_signal);
      lim++;
    end
    chk("delay_cycles", 32'(n), 32'(exp_cycles));
    chk("delay_then_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int st_cyc[3];
  int st_nr[3];
  int r;

  initial begin
    model_init();
    repeat (3) @(negedge osc_signal);
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(push_ready), 32'd1);
    chk("rst_start", 32'(cmd_start), 32'd0);
    reset_n = 1'b1;

    // Spurious done while idle
    pulse_done(12'd0);
    repeat (2) @(negedge osc_signal);
    chk("spur_status", 32'(status), 32'h00);
    chk("spur_idle", 32'(idle), 32'd1);

    // Single command
    push(4'd3, 8'hA5);
    chk("single_k_start", 32'(cmd_start), 32'd0);
    @(negedge osc_signal);
    chk("single_k1_start", 32'(cmd_start), 32'd0);
    @(negedge osc_signal);
    chk("single_k2_start", 32'(cmd_start), 32'd1);
    chk("single_nr", 32'(cmd_nr), 32'd3);
    chk("single_arg", 32'(cmd_arg), 32'hA5);
    @(negedge osc_signal);
    chk("single_pulse_len", 32'(cmd_start), 32'd0);
    chk("single_run_status", 32'(status), 32'h40);
    pulse_done(12'd0);
    @(negedge osc_signal);
    chk("single_done_status", 32'(status), 32'h00);
    chk("single_done_idle", 32'(idle), 32'd1);

    // Ordering and minimum spacing
    for (int i = 0; i < 3; i++) begin
      st_cyc[i] = 0;
      st_nr[i]  = 0;
    end
    push(4'd1, 8'h10);
    push(4'd2, 8'h20);
    push(4'd3, 8'h30);
    for (int i = 0; i < 3; i++) begin
      int lim;
      lim = 0;
      while (!cmd_start && lim < 20) begin
        @(negedge osc_signal);
        cmd_done = 1'b0;
        lim++;
      end
      if (cmd_start) begin
        st_cyc[i]    = cyc;
        st_nr[i]     = int'(cmd_nr);
        cmd_done     = 1'b1;
        cmd_delay_us = 12'd0;
      end
      @(negedge osc_signal);
      cmd_done = 1'b0;
    end
    chk("order_nr0", 32'(st_nr[0]), 32'd1);
    chk("order_nr1", 32'(st_nr[1]), 32'd2);
    chk("order_nr2", 32'(st_nr[2]), 32'd3);
    chk("order_gap01", 32'(st_cyc[1] - st_cyc[0]), 32'd3);
    chk("order_gap12", 32'(st_cyc[2] - st_cyc[1]), 32'd3);
    repeat (3) @(negedge osc_signal);

    // Overflow while the engine is stalled, then flush
    push(4'd7, 8'h11);
    wait_start(10);
    for (int i = 0; i < 5; i++) push(4'(i + 8), 8'(i));
    @(negedge osc_signal);
    chk("ovf_status", 32'(status), 32'hC4);
    chk("ovf_ready", 32'(push_ready), 32'd0);
    flush = 1'b1;
    @(negedge osc_signal);
    flush = 1'b0;
    @(negedge osc_signal);
    chk("flush_status", 32'(status), 32'h40);
    chk("flush_ready", 32'(push_ready), 32'd1);
    chk("flush_cmd_held", 32'(cmd_nr), 32'd7);
    pulse_done(12'd0);
    @(negedge osc_signal);
    chk("flush_complete_idle", 32'(idle), 32'd1);
    chk("flush_complete_status", 32'(status), 32'h00);

    // 10 us delay
    push(4'd2, 8'h20);
    wait_start(10);
    measure_delay(12'd10, 240);

    // Reset in the middle of a 100 us delay
    push(4'd5, 8'h3C);
    wait_start(10);
    pulse_done(12'd100);
    repeat (50) @(negedge osc_signal);
    chk("pre_rst_dly", 32'(status[5]), 32'd1);
    #2;
    reset_n = 1'b0;
    model_init();
    #1;
    chk("arst_status", 32'(status), 32'h00);
    chk("arst_idle", 32'(idle), 32'd1);
    chk("arst_start", 32'(cmd_start), 32'd0);
    chk("arst_nr", 32'(cmd_nr), 32'd0);
    chk("arst_arg", 32'(cmd_arg), 32'd0);
    chk("arst_ready", 32'(push_ready), 32'd1);
    @(negedge osc_signal);
    reset_n = 1'b1;
    push(4'd9, 8'h42);
    wait_start(10);
    chk("post_rst_nr", 32'(cmd_nr), 32'd9);
    chk("post_rst_arg", 32'(cmd_arg), 32'h42);

    // Saturating delay: 4000 us clamps to 2730 us
    measure_delay(12'd4000, 65520);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge osc_signal);
      push_valid = ($urandom_range(0, 99) < 40);
      push_cmd   = 4'($urandom);
      push_arg   = 8'($urandom);
      flush      = ($urandom_range(0, 99) < 3);
      cmd_done   = ($urandom_range(0, 99) < 25);
      r          = int'($urandom_range(0, 99));
      if (r < 55)      cmd_delay_us = 12'd0;
      else if (r < 90) cmd_delay_us = 12'($urandom_range(1, 3));
      else             cmd_delay_us = 12'($urandom_range(4, 10));
    end
    @(negedge osc_signal);
    push_valid   = 1'b0;
    flush        = 1'b0;
    cmd_done     = 1'b0;
    cmd_delay_us = 12'd0;
    repeat (5) @(negedge osc_signal);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
